// File: rtl/debounce_step_gen.sv
// -----------------------------------------------------------------------------
// debounce_step_gen
//   Upstream stage for the 4-bit LED counter demo. A raw, bouncing push-button
//   is synchronized into clk, debounced, and turned into single-cycle step
//   pulses. Holding the button down auto-repeats the step after a delay.
//
// Ports
//   clk            in   system clock, everything rises on posedge
//   rst_n          in   asynchronous, active-low reset
//   btn_in         in   raw button, asynchronous to clk, active-high
//   step           out  one-cycle increment pulse (registered)
//   pressed        out  debounced button level (registered)
//   repeat_active  out  high while auto-repeat is running (registered)
// -----------------------------------------------------------------------------
module debounce_step_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic step,
  output logic pressed,
  output logic repeat_active
);

  localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_HOLD    = 3'd2,
    S_REPEAT  = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_btn_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_step_evt;

  logic                   w_step_d;
  logic                   w_pressed_d;
  logic                   w_repeat_d;

  // Synchronizer: btn_in shifts in at bit 0, the debouncer only sees the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign w_btn_s = r_sync[SYNC_STAGES-1];

  // Saturating increment so the shared counter can never wrap.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE;

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      step          <= 1'b0;
      pressed       <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      step          <= w_step_d;
      pressed       <= w_pressed_d;
      repeat_active <= w_repeat_d;
    end
  end

  // Next-state logic. The btn_s test always comes first so that a level change
  // coinciding with a counter terminal value wins and suppresses the step.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    w_step_evt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_btn_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = S_HOLD;
            w_step_evt  = 1'b1;
          end else begin
            // The sample that leaves IDLE already counts as the first one.
            w_state_nxt = S_ARM;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      S_ARM: begin
        if (!w_btn_s) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_step_evt  = 1'b1;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!w_btn_s) begin
          // A single-sample debounce has nothing left to confirm on release.
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_RELEASE;
            w_cnt_nxt   = CNT_ONE;
          end
        end else if (r_state == S_HOLD && r_cnt == DLY_LAST) begin
          w_state_nxt = S_REPEAT;
          w_cnt_nxt   = '0;
          w_step_evt  = 1'b1;
        end else if (r_state == S_REPEAT && r_cnt == PER_LAST) begin
          w_cnt_nxt  = '0;
          w_step_evt = 1'b1;
        end
      end
      S_RELEASE: begin
        if (w_btn_s) begin
          // Bounce back to high: stay pressed but restart the repeat delay.
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode, evaluated on the next state so the outputs are registered
  // yet line up with the state they describe.
  always_comb begin
    w_step_d    = w_step_evt;
    w_pressed_d = 1'b0;
    w_repeat_d  = 1'b0;
    case (w_state_nxt)
      S_HOLD, S_RELEASE: w_pressed_d = 1'b1;
      S_REPEAT: begin
        w_pressed_d = 1'b1;
        w_repeat_d  = 1'b1;
      end
      default: begin
        w_pressed_d = 1'b0;
        w_repeat_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_debounce_step_gen.sv
// -----------------------------------------------------------------------------
// tb_debounce_step_gen
//   Self-checking bench for debounce_step_gen with SYNC_STAGES=2, DEBOUNCE=4,
//   REPEAT_DELAY=20, REPEAT_PERIOD=5. Every cycle is compared against a
//   run-length / time-since-press model; directed scenarios add explicit
//   checks on step timing, release timing and a downstream 4-bit counter.
// -----------------------------------------------------------------------------
module tb_debounce_step_gen;

  localparam int SYNC_STAGES = 2;
  localparam int DEB         = 4;
  localparam int RDLY        = 20;
  localparam int RPER        = 5;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic btn_in = 1'b0;
  logic step;
  logic pressed;
  logic repeat_active;

  always #5 clk = ~clk;

  debounce_step_gen #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .step         (step),
    .pressed      (pressed),
    .repeat_active(repeat_active)
  );

  // Downstream 4-bit LED counter driven by step.
  logic [3:0] r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else if (step) r_count <= r_count + 4'd1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: btn_s is btn_in delayed SYNC_STAGES samples. A press is
  // accepted once DEB consecutive highs are seen; a release once DEB
  // consecutive lows are seen. While accepted and high, steps fall at
  // RDLY, RDLY+RPER, ... samples after the anchor (acceptance, or return to
  // high during a release bounce).
  logic m_q[$];
  bit   m_deb, m_last, m_step, m_pr, m_ra;
  int   m_run, m_t;

  task automatic model_reset();
    m_q.delete();
    m_deb = 0; m_last = 0; m_run = 0; m_t = 0;
    m_step = 0; m_pr = 0; m_ra = 0;
  endtask

  task automatic model_edge(input logic b_in);
    logic b;
    m_q.push_back(b_in);
    if (m_q.size() > SYNC_STAGES) b = m_q.pop_front();
    else b = 1'b0;
    if (b == m_last) m_run++;
    else m_run = 1;
    m_last = b;
    m_step = 0;
    if (!m_deb) begin
      if (b && m_run >= DEB) begin
        m_deb = 1; m_step = 1; m_t = 0;
      end
    end else if (!b) begin
      if (m_run >= DEB) m_deb = 0;
      m_t = 0;
    end else if (m_run == 1) begin
      m_t = 0;
    end else begin
      m_t++;
      m_step = (m_t == RDLY) || (m_t > RDLY && ((m_t - RDLY) % RPER) == 0);
    end
    m_pr = m_deb;
    m_ra = m_deb && b && (m_t >= RDLY);
  endtask

  // Trace of the current scenario, cycle numbers counted from reset release.
  int cyc;
  int step_q[$];
  int first_ra;
  int fall_cyc;
  bit prev_pr;

  task automatic clear_trace();
    cyc = 0; step_q.delete(); first_ra = -1; fall_cyc = -1; prev_pr = 0;
  endtask

  task automatic tick(input logic b);
    btn_in = b;
    @(posedge clk);
    model_edge(b);
    #1;
    cyc++;
    check("out", {29'd0, step, pressed, repeat_active}, {29'd0, m_step, m_pr, m_ra});
    if (step === 1'b1) step_q.push_back(cyc);
    if (repeat_active === 1'b1 && first_ra < 0) first_ra = cyc;
    if (prev_pr && pressed === 1'b0) fall_cyc = cyc;
    prev_pr = (pressed === 1'b1);
  endtask

  task automatic ticks(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b);
  endtask

  // Assert reset away from the clock edge and confirm outputs clear without
  // waiting for clk; release it just after an edge.
  task automatic do_reset(input logic b);
    btn_in = b;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", {29'd0, step, pressed, repeat_active}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", {29'd0, step, pressed, repeat_active}, 32'd0);
    rst_n = 1'b1;
    clear_trace();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    clear_trace();
    model_reset();

    // Reset with button held: first step 6 edges after release, then an
    // asynchronous reset in the middle of auto-repeat.
    do_reset(1'b1);
    ticks(1'b1, 40);
    check("t1_first_step", (step_q.size() > 0) ? step_q[0] : -1, 6);
    check("t1_ra_before", {31'd0, repeat_active}, 32'd1);
    do_reset(1'b0);

    // Glitch shorter than the debounce window.
    ticks(1'b0, 3);
    ticks(1'b1, 3);
    ticks(1'b0, 12);
    check("t2_nostep", step_q.size(), 0);
    check("t2_pressed", {31'd0, pressed}, 32'd0);

    // Long hold: 60 high samples at btn_s.
    do_reset(1'b0);
    ticks(1'b1, 60);
    ticks(1'b0, 10);
    check("t3_nsteps", step_q.size(), 9);
    for (int i = 0; i < step_q.size() && i < 9; i++)
      check("t3_step_at", step_q[i], (i == 0) ? 6 : 26 + RPER * (i - 1));
    check("t3_ra_rise", first_ra, 26);
    check("t3_fall", fall_cyc, 66);

    // Release bounce: low 2 / high 1 / low 10.
    do_reset(1'b0);
    ticks(1'b1, 10);
    ticks(1'b0, 2);
    ticks(1'b1, 1);
    ticks(1'b0, 10);
    check("t4_nsteps", step_q.size(), 1);
    check("t4_fall", fall_cyc, 19);

    // Release bounce that returns to a long hold: the repeat delay restarts.
    do_reset(1'b0);
    ticks(1'b1, 10);
    ticks(1'b0, 2);
    ticks(1'b1, 30);
    ticks(1'b0, 10);
    check("t4b_nsteps", step_q.size(), 3);
    check("t4b_restart", (step_q.size() > 1) ? step_q[1] : -1, 35);
    check("t4b_period", (step_q.size() > 2) ? step_q[2] : -1, 40);

    // Release on the same edge the repeat delay expires.
    do_reset(1'b0);
    ticks(1'b1, 23);
    ticks(1'b0, 3);
    check("t5_nsteps", step_q.size(), 1);
    check("t5_pressed", {31'd0, pressed}, 32'd1);
    check("t5_ra", {31'd0, repeat_active}, 32'd0);
    ticks(1'b0, 6);
    check("t5_released", {31'd0, pressed}, 32'd0);

    // System: 17 clean presses into the 4-bit counter wrap it to 1.
    do_reset(1'b0);
    for (int i = 0; i < 17; i++) begin
      ticks(1'b1, 8);
      ticks(1'b0, 8);
      check("t6_count", {28'd0, r_count}, (i + 1) % 16);
    end
    check("t6_final", {28'd0, r_count}, 32'd1);

    // Random bouncy button with occasional long holds and resets.
    do_reset(1'b0);
    for (int blk = 0; blk < 160; blk++) begin
      logic lvl;
      int   len;
      lvl = logic'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 90) : $urandom_range(1, 8);
      ticks(lvl, len);
      if ($urandom_range(0, 49) == 0) do_reset(logic'($urandom_range(0, 1)));
    end
    ticks(1'b0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
